// File: rtl/io_timer_pkg.sv
// rtl/io_timer_pkg.sv - shared constants, responder state type and byte-lane merge for io_timer
package io_timer_pkg;

  localparam logic [4:0] TMR_CTRL     = 5'h00;
  localparam logic [4:0] TMR_PRESCALE = 5'h04;
  localparam logic [4:0] TMR_COUNT    = 5'h08;
  localparam logic [4:0] TMR_COMPARE  = 5'h0C;
  localparam logic [4:0] TMR_STATUS   = 5'h10;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_RD = 2'd1,
    RESP_WR = 2'd2
  } io_rsp_state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_tick_gen.sv
// rtl/io_tick_gen.sv - prescaler producing one tick every prescale+1 enabled cycles
module io_tick_gen
  import io_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? 16'd0 : pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// rtl/io_timer.sv - memory-mapped timer responder on the data-side IO port
module io_timer
  import io_timer_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       io_addr,
  input  logic              io_rd_req,
  input  logic              io_wr_req,
  input  logic [XLEN/8-1:0] io_be,
  input  logic [XLEN-1:0]   io_wr_data,
  output logic [XLEN-1:0]   io_rd_data,
  output logic              io_rd_ready,
  output logic              io_wr_ready,
  output logic              irq
);

  io_rsp_state_t state, state_nxt;

  logic [2:0]      ctrl;
  logic [15:0]     prescale;
  logic [31:0]     count;
  logic [31:0]     compare;
  logic            match;
  logic [XLEN-1:0] rd_q;

  logic        in_win;
  logic [4:0]  offset;
  logic [31:0] reg_val;
  logic [31:0] wr_val;
  logic        wr_commit, rd_capture;
  logic        wr_ctrl, wr_pre, wr_cnt, wr_cmp, wr_sts;
  logic        tick, cnt_hit;
  logic        rd_pulse, wr_pulse;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^io_addr[1:0];

  assign in_win = (io_addr[15:5] == BASE_ADDR[15:5]);
  assign offset = {io_addr[4:2], 2'b00};

  always_comb begin
    reg_val = '0;
    if (in_win) begin
      case (offset)
        TMR_CTRL:     reg_val = {29'd0, ctrl};
        TMR_PRESCALE: reg_val = {16'd0, prescale};
        TMR_COUNT:    reg_val = count;
        TMR_COMPARE:  reg_val = compare;
        TMR_STATUS:   reg_val = {31'd0, match};
        default:      reg_val = '0;
      endcase
    end
  end

  // Lanes with io_be clear keep the register's current value.
  assign wr_val     = be_merge(reg_val, io_wr_data, io_be);
  assign wr_commit  = (state == IDLE) && io_wr_req;
  assign rd_capture = (state == IDLE) && !io_wr_req && io_rd_req;

  assign wr_ctrl = wr_commit && in_win && (offset == TMR_CTRL);
  assign wr_pre  = wr_commit && in_win && (offset == TMR_PRESCALE);
  assign wr_cnt  = wr_commit && in_win && (offset == TMR_COUNT);
  assign wr_cmp  = wr_commit && in_win && (offset == TMR_COMPARE);
  assign wr_sts  = wr_commit && in_win && (offset == TMR_STATUS);

  assign cnt_hit = (count == compare);

  io_tick_gen u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl[CTRL_EN]),
    .prescale (prescale),
    .clr      (wr_pre),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= 32'hFFFF_FFFF;
      match    <= 1'b0;
      rd_q     <= '0;
    end else begin
      if (wr_ctrl) ctrl <= wr_val[2:0];
      if (wr_pre)  prescale <= wr_val[15:0];
      if (wr_cmp)  compare <= wr_val;
      // A software write to COUNT takes priority over the tick update.
      if (wr_cnt) begin
        count <= wr_val;
      end else if (tick) begin
        count <= (cnt_hit && ctrl[CTRL_AUTO_RELOAD]) ? 32'd0 : count + 32'd1;
      end
      if (tick && cnt_hit) begin
        match <= 1'b1;
      end else if (wr_sts && io_be[0] && io_wr_data[0]) begin
        match <= 1'b0;
      end
      if (rd_capture) rd_q <= reg_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_pulse  = 1'b0;
    wr_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (io_wr_req)      state_nxt = RESP_WR;
        else if (io_rd_req) state_nxt = RESP_RD;
      end
      RESP_RD: begin
        rd_pulse  = 1'b1;
        state_nxt = IDLE;
      end
      RESP_WR: begin
        wr_pulse  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so a response in flight is dropped.
  assign io_rd_ready = rd_pulse && !rst;
  assign io_wr_ready = wr_pulse && !rst;
  assign io_rd_data  = io_rd_ready ? rd_q : '0;
  assign irq         = match && ctrl[CTRL_IRQ_EN] && !rst;

endmodule
